fifo_rr_arbiter: RTL
====================

# fifo_rr_arbiter

Round-robin arbiter that drains FIFO_UNITS input FIFOs into a single output FIFO, one word per cycle. It sits between the per-class input FIFOs and the shared output FIFO, and generates the one-hot pops that the pop counter monitors. The arbiter skips empty sources and backs off while the output FIFO reports almost-full. It exports its state for the top-level state machine.

## Interface
- FIFO_UNITS, 4: number of input FIFOs.
- INDEX, 2: width of the source index, log2(FIFO_UNITS).
- DATA_WIDTH, 6: word width.
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  arbitration allowed when 1.
- fifo_empty  input  FIFO_UNITS  per-source empty flag, bit i for FIFO i.
- fifo_data  input  FIFO_UNITS*DATA_WIDTH  show-ahead head words; FIFO i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- out_almost_full  input  1  output FIFO almost-full flag.
- pop  output  FIFO_UNITS  one-hot pop to the granted source; combinational.
- push  output  1  registered write strobe to the output FIFO.
- data_out  output  DATA_WIDTH  registered word accompanying push.
- grant_idx  output  INDEX  registered index of the source written by the current push.
- state  output  2  current FSM state.
- idle  output  1  registered; 1 when in IDLE with no push in flight.
- xfer_count  output  5  registered count of words transferred; wraps modulo 32.

## Operation
- States: RESET=0, IDLE=1, ACTIVE=2, STALL=3.
- Define `any_req = |(~fifo_empty)` and `go = enable & any_req & ~out_almost_full`.
- RESET: entered asynchronously while reset=0. On the first clock edge after release, the FSM moves to IDLE.
- IDLE, ACTIVE and STALL: the next state is evaluated every cycle.
  - ACTIVE if go.
  - STALL if any_req & (out_almost_full | ~enable).
  - IDLE otherwise.
- Grant (combinational):
  - When go=1 and the state is not RESET, pop gets exactly one bit.
  - That bit belongs to the first non-empty source found by searching upward from ptr, wrapping at FIFO_UNITS-1 back to 0.
  - Otherwise pop=0.
- Pointer:
  - ptr is INDEX bits wide and resets to 0.
  - On a grant to source i, ptr becomes (i+1) mod FIFO_UNITS.
  - Without a grant, ptr holds.
- Transfer:
  - The edge that ends a grant cycle registers push=1, data_out=fifo_data[i], grant_idx=i, and xfer_count+1.
  - Without a grant, push=0; data_out and grant_idx hold.
- idle is set to 1 when the next state is IDLE and no grant occurred in the current cycle.
- pop never targets a source whose fifo_empty is 1.
- pop is 0 whenever out_almost_full=1 in the same cycle.

## Timing
- Reset values (asynchronous, immediate):
  - pop=0, push=0, data_out=0, grant_idx=0.
  - state=RESET, idle=0, xfer_count=0, ptr=0.
- Latency: pop in cycle n is followed by push and data in cycle n+1, i.e. one cycle.
- Throughput: one word per cycle while go holds.
- out_almost_full:
  - Sampled combinationally; it blocks new pops in the same cycle.
  - A push already registered still completes; the output FIFO's almost-full threshold must leave at least one free slot.
- Reset asserted mid-transfer: any pending push is dropped and outputs clear at once. Arbitration restarts from source 0.
- When only one source is non-empty, it is granted every cycle.
- Changes to enable take effect in the same cycle.

## Structure
- The shared package holds:
  - state encodings ST_RESET, ST_IDLE, ST_ACTIVE, ST_STALL;
  - default FIFO_UNITS, INDEX and DATA_WIDTH;
  - the xfer_count width of 5.
- One natural sub-module, rr_select: a combinational rotate-and-priority-encode. Inputs are req and ptr; outputs are a one-hot grant and its index.
- The FSM, pointer, output registers and counter live in fifo_rr_arbiter.

## Test plan
- Reset release, all FIFOs empty, enable=1:
  - expect state RESET, then IDLE;
  - expect idle=1, pop=0, push=0, xfer_count=0.
- All four FIFOs non-empty for 8 cycles:
  - pop sequence 0001, 0010, 0100, 1000, then repeats;
  - push follows one cycle later with grant_idx 0,1,2,3,0,…;
  - xfer_count reaches 8.
- fifo_empty=4'b1010 with ptr=1: grants go 2, 0, 2, 0; sources 1 and 3 are never popped.
- out_almost_full=1 for 3 cycles with data pending:
  - pop=0 and state=STALL;
  - the push from the cycle before still occurs;
  - on release the arbiter resumes from the saved ptr.
- Reset pulsed low for one half-cycle right after a pop: push is never asserted for that word, all outputs read 0, and ptr restarts at 0.
- 33 consecutive transfers: xfer_count wraps to 1.

Source files
------------

// File: rtl/fifo_rr_arbiter_pkg.sv
// fifo_rr_arbiter_pkg
// Shared definitions for the round-robin FIFO drain arbiter:
//   - FSM state encoding (state_t) exported on the arbiter's state port
//   - default FIFO_UNITS / INDEX / DATA_WIDTH parameter values
//   - width of the transferred-word counter (XFER_W)
package fifo_rr_arbiter_pkg;

    localparam int FIFO_UNITS_DEF = 4;
    localparam int INDEX_DEF      = 2;
    localparam int DATA_WIDTH_DEF = 6;
    localparam int XFER_W         = 5;

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_STALL  = 2'd3
    } state_t;

endpackage

// File: rtl/fifo_rr_arbiter_rr_select.sv
// rr_select
// Combinational round-robin selector: searches req upward starting at ptr,
// wrapping from N-1 back to 0, and returns the first requester found.
// Ports:
//   req       [N-1:0]  request vector, bit i = source i wants service
//   ptr       [IW-1:0] highest-priority source this cycle
//   gnt       [N-1:0]  one-hot grant (all zero when no request)
//   gnt_idx   [IW-1:0] index of the granted source (0 when no request)
//   gnt_valid          1 when some source was selected
module rr_select
    import fifo_rr_arbiter_pkg::*;
#(
    parameter int N  = FIFO_UNITS_DEF,
    parameter int IW = INDEX_DEF
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_valid
);

    always_comb begin
        int            cand;
        logic [IW-1:0] cidx;
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        cand      = 0;
        cidx      = '0;
        // Walk offsets 0..N-1 from ptr; the first hit locks out later ones.
        for (int k = 0; k < N; k++) begin
            cand = int'(ptr) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            cidx = IW'(cand);
            if (!gnt_valid && req[cidx]) begin
                gnt[cidx] = 1'b1;
                gnt_idx   = cidx;
                gnt_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// fifo_rr_arbiter
// Drains FIFO_UNITS show-ahead input FIFOs into one output FIFO, one word per
// cycle, in round-robin order, skipping empty sources and backing off while
// the output FIFO is almost full.
// Ports:
//   clk              system clock, rising edge
//   reset            asynchronous, active-low reset
//   enable           arbitration allowed when 1 (takes effect same cycle)
//   fifo_empty       per-source empty flags
//   fifo_data        per-source head words, source i at [i*DATA_WIDTH +: DATA_WIDTH]
//   out_almost_full  output FIFO back-pressure
//   pop              one-hot pop to the granted source (combinational)
//   push             registered write strobe to the output FIFO
//   data_out         registered word accompanying push
//   grant_idx        registered source index of the current push
//   state            current FSM state (state_t encoding)
//   idle             registered; 1 in IDLE with no push in flight
//   xfer_count       registered count of transferred words, wraps mod 32
//
// Handshake: pop[i] is a same-cycle consume strobe on source i's show-ahead
// head word and is only raised when that source is non-empty; push is a
// valid strobe qualifying data_out/grant_idx for exactly one cycle. The
// output FIFO has no ready; out_almost_full is the only back-pressure and
// blocks pops in the same cycle, so a push already registered still lands.
module fifo_rr_arbiter
    import fifo_rr_arbiter_pkg::*;
#(
    parameter int FIFO_UNITS = FIFO_UNITS_DEF,
    parameter int INDEX      = INDEX_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             enable,
    input  logic [FIFO_UNITS-1:0]            fifo_empty,
    input  logic [FIFO_UNITS*DATA_WIDTH-1:0] fifo_data,
    input  logic                             out_almost_full,
    output logic [FIFO_UNITS-1:0]            pop,
    output logic                             push,
    output logic [DATA_WIDTH-1:0]            data_out,
    output logic [INDEX-1:0]                 grant_idx,
    output logic [1:0]                       state,
    output logic                             idle,
    output logic [XFER_W-1:0]                xfer_count
);

    state_t                  cur_state;
    state_t                  nxt_state;
    logic [INDEX-1:0]        ptr;
    logic                    any_req;
    logic                    go;
    logic                    grant;
    logic [FIFO_UNITS-1:0]   sel_gnt;
    logic [INDEX-1:0]        sel_idx;
    logic                    sel_valid;
    logic [DATA_WIDTH-1:0]   sel_word;

    assign any_req = |(~fifo_empty);
    assign go      = enable & any_req & ~out_almost_full;

    rr_select #(
        .N  (FIFO_UNITS),
        .IW (INDEX)
    ) u_rr_select (
        .req       (~fifo_empty),
        .ptr       (ptr),
        .gnt       (sel_gnt),
        .gnt_idx   (sel_idx),
        .gnt_valid (sel_valid)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_state <= ST_RESET;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // Next-state logic: RESET always leaves to IDLE on the first edge.
    always_comb begin
        nxt_state = ST_IDLE;
        if (cur_state != ST_RESET) begin
            if (go) begin
                nxt_state = ST_ACTIVE;
            end else if (any_req && (out_almost_full || !enable)) begin
                nxt_state = ST_STALL;
            end else begin
                nxt_state = ST_IDLE;
            end
        end
    end

    // Output logic: a grant needs go and a live FSM.
    always_comb begin
        grant = go && sel_valid && (cur_state != ST_RESET);
        pop   = grant ? sel_gnt : '0;
    end

    // Head word of the selected source.
    always_comb begin
        sel_word = '0;
        for (int i = 0; i < FIFO_UNITS; i++) begin
            if (sel_idx == INDEX'(i)) begin
                sel_word = fifo_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Pointer, transfer registers and counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr        <= '0;
            push       <= 1'b0;
            data_out   <= '0;
            grant_idx  <= '0;
            idle       <= 1'b0;
            xfer_count <= '0;
        end else begin
            push <= grant;
            idle <= (nxt_state == ST_IDLE) && !grant;
            if (grant) begin
                ptr        <= (sel_idx == INDEX'(FIFO_UNITS - 1)) ? '0 : sel_idx + INDEX'(1);
                data_out   <= sel_word;
                grant_idx  <= sel_idx;
                xfer_count <= xfer_count + XFER_W'(1);
            end
        end
    end

    assign state = cur_state;

endmodule
